// File: rtl/fpalu_pkg.sv
// Shared widths, bias and opcode encodings for the 29-bit add/sub ALU.
package fpalu_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 22;
  localparam int BIAS  = 31;
  localparam int GRS_W = 3;

  localparam logic [1:0] OP_SUBR = 2'b00;
  localparam logic [1:0] OP_ADDR = 2'b01;
  localparam logic [1:0] OP_SUBI = 2'b10;
  localparam logic [1:0] OP_ADDI = 2'b11;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

endpackage

// File: rtl/fpalu_lzc.sv
// 23-bit leading-zero counter; an all-zero input reports 23.
module fpalu_lzc (
  input  logic [22:0] vec_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd23;
    // Ascending scan: the highest set bit is the last write.
    for (int i = 0; i < 23; i++) begin
      if (vec_i[i]) cnt_o = 5'(22 - i);
    end
  end

endmodule

// File: rtl/fpalu.sv
// Single-stage 29-bit float add/sub with RNE or truncation; one result per cycle, 1-cycle latency.
// Overflow gives the infinity code unless FPALU_SAT_EN is defined, which saturates to max magnitude.
module fpalu
  import fpalu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       opcode,
  input  logic             din_uni_a_sgn,
  input  logic [EXP_W-1:0] din_uni_a_exp,
  input  logic [MAN_W-1:0] din_uni_a_man_dn,
  input  logic             din_uni_b_sgn,
  input  logic [EXP_W-1:0] din_uni_b_exp,
  input  logic [MAN_W-1:0] din_uni_b_man_dn,
  output logic             dout_uni_y_sgn,
  output logic [EXP_W-1:0] dout_uni_y_exp,
  output logic [MAN_W-1:0] dout_uni_y_man_dn
);

  localparam int EXT_W = MAN_W + GRS_W;

  fp_t              y_d, y_q;
  fp_t              big, sml;
  logic             eff_b_sgn, a_is_big, sub_op, res_sgn;
  logic [EXP_W-1:0] exp_diff;
  logic [2*EXT_W-1:0] sml_wide;
  logic [EXT_W-1:0] sml_al, big_ext, mag_diff, v, v_n;
  logic [EXT_W:0]   res;
  logic [EXP_W:0]   exp_pre, shamt, exp_n, exp_f;
  logic [4:0]       lz;
  logic [MAN_W-1:0] man_n, man_f;
  logic [MAN_W:0]   man_inc;
  logic             rnd_up;

  fpalu_lzc u_lzc (
    .vec_i (v[EXT_W-1:2]),
    .cnt_o (lz)
  );

  always_comb begin
    eff_b_sgn = din_uni_b_sgn ^ ~opcode[0];
    sub_op    = din_uni_a_sgn ^ eff_b_sgn;
    // A zero-mantissa operand never wins the swap, whatever its exponent.
    a_is_big  = (~|din_uni_b_man_dn) |
                ((|din_uni_a_man_dn) &
                 ((din_uni_a_exp > din_uni_b_exp) |
                  ((din_uni_a_exp == din_uni_b_exp) && (din_uni_a_man_dn >= din_uni_b_man_dn))));
    if (a_is_big) begin
      big = '{din_uni_a_sgn, din_uni_a_exp, din_uni_a_man_dn};
      sml = '{eff_b_sgn, din_uni_b_exp, din_uni_b_man_dn};
    end else begin
      big = '{eff_b_sgn, din_uni_b_exp, din_uni_b_man_dn};
      sml = '{din_uni_a_sgn, din_uni_a_exp, din_uni_a_man_dn};
    end

    exp_diff = big.exp - sml.exp;
    sml_wide = {sml.man, {GRS_W{1'b0}}, {EXT_W{1'b0}}} >> exp_diff;
    if (exp_diff >= EXP_W'(EXT_W))
      sml_al = {{(EXT_W-1){1'b0}}, |sml.man};
    else
      sml_al = {sml_wide[2*EXT_W-1:EXT_W+1], sml_wide[EXT_W] | (|sml_wide[EXT_W-1:0])};
    big_ext = {big.man, {GRS_W{1'b0}}};

    res_sgn  = big.sgn;
    mag_diff = big_ext - sml_al;
    // Unnormalized inputs can make the aligned small operand the larger magnitude.
    if (sub_op && (sml_al > big_ext)) begin
      mag_diff = sml_al - big_ext;
      res_sgn  = ~big.sgn;
    end
    res = sub_op ? {1'b0, mag_diff} : ({1'b0, big_ext} + {1'b0, sml_al});

    if (res[EXT_W]) begin
      v       = {res[EXT_W:2], res[1] | res[0]};
      exp_pre = {1'b0, big.exp} + 7'd1;
    end else begin
      v       = res[EXT_W-1:0];
      exp_pre = {1'b0, big.exp};
    end

    shamt = ({2'b0, lz} < exp_pre) ? {2'b0, lz} : exp_pre;
    v_n   = v << shamt;
    exp_n = exp_pre - shamt;
    man_n = v_n[EXT_W-1:GRS_W];

    rnd_up  = ~opcode[1] & v_n[2] & (v_n[1] | v_n[0] | man_n[0]);
    man_inc = {1'b0, man_n} + 23'd1;
    man_f   = man_n;
    exp_f   = exp_n;
    if (rnd_up) begin
      if (man_inc[MAN_W]) begin
        man_f = 22'h200000;
        exp_f = exp_n + 7'd1;
      end else begin
        man_f = man_inc[MAN_W-1:0];
      end
    end

    if (~|man_f) begin
      y_d = '0;
    end else if (exp_f[EXP_W]) begin
`ifdef FPALU_SAT_EN
      y_d = '{res_sgn, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
`else
      y_d = '{res_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
    end else begin
      y_d = '{res_sgn, exp_f[EXP_W-1:0], man_f};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign dout_uni_y_sgn    = y_q.sgn;
  assign dout_uni_y_exp    = y_q.exp;
  assign dout_uni_y_man_dn = y_q.man;

endmodule

// File: tb/tb_fpalu.sv
// Directed scoreboard bench for fpalu: expected results queued at drive time, popped one cycle later.
module tb_fpalu;
  import fpalu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       opcode;
  logic             a_sgn, b_sgn;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             y_sgn;
  logic [EXP_W-1:0] y_exp;
  logic [MAN_W-1:0] y_man;

  logic [28:0] sb_q[$];
  int checks = 0;
  int passed = 0;

  localparam logic [EXP_W-1:0] E1 = EXP_W'(BIAS);
`ifdef FPALU_SAT_EN
  localparam logic [28:0] OVF = {1'b0, 6'd63, 22'h3FFFFF};
`else
  localparam logic [28:0] OVF = {1'b0, 6'd63, 22'h000000};
`endif

  always #5 clk = ~clk;

  fpalu dut (
    .clk               (clk),
    .rst               (rst),
    .opcode            (opcode),
    .din_uni_a_sgn     (a_sgn),
    .din_uni_a_exp     (a_exp),
    .din_uni_a_man_dn  (a_man),
    .din_uni_b_sgn     (b_sgn),
    .din_uni_b_exp     (b_exp),
    .din_uni_b_man_dn  (b_man),
    .dout_uni_y_sgn    (y_sgn),
    .dout_uni_y_exp    (y_exp),
    .dout_uni_y_man_dn (y_man)
  );

  function automatic logic [28:0] fp(input logic s, input logic [5:0] e, input logic [21:0] m);
    return {s, e, m};
  endfunction

  task automatic step(input string tag, input logic [1:0] op,
                      input logic [28:0] a, input logic [28:0] b, input logic [28:0] y);
    logic [28:0] exp_v;
    logic [28:0] obs;
    opcode = op;
    {a_sgn, a_exp, a_man} = a;
    {b_sgn, b_exp, b_man} = b;
    sb_q.push_back(y);
    @(posedge clk);
    #1;
    obs = {y_sgn, y_exp, y_man};
    checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    step("reset", OP_ADDI, fp(0, E1, 22'h200000), fp(0, E1, 22'h200000), 29'h0);
    rst = 1'b0;

    step("1p1",       OP_ADDI, fp(0, E1, 22'h200000), fp(0, E1, 22'h200000), fp(0, 6'd32, 22'h200000));
    step("1m1",       OP_SUBI, fp(0, E1, 22'h200000), fp(0, E1, 22'h200000), 29'h0);
    step("1.5p0.25",  OP_ADDI, fp(0, 6'd31, 22'h300000), fp(0, 6'd29, 22'h200000), fp(0, 6'd31, 22'h380000));
    step("rne_up",    OP_ADDR, fp(0, 6'd31, 22'h200000), fp(0, 6'd9, 22'h300000), fp(0, 6'd31, 22'h200001));
    step("trunc",     OP_ADDI, fp(0, 6'd31, 22'h200000), fp(0, 6'd9, 22'h300000), fp(0, 6'd31, 22'h200000));
    step("tie_even",  OP_ADDR, fp(0, 6'd31, 22'h200000), fp(0, 6'd9, 22'h200000), fp(0, 6'd31, 22'h200000));
    step("tie_odd",   OP_ADDR, fp(0, 6'd31, 22'h200001), fp(0, 6'd9, 22'h200000), fp(0, 6'd31, 22'h200002));
    step("neg_sub",   OP_SUBI, fp(0, 6'd31, 22'h200000), fp(0, 6'd32, 22'h200000), fp(1, 6'd31, 22'h200000));
    step("neg_add",   OP_ADDI, fp(1, 6'd31, 22'h300000), fp(1, 6'd30, 22'h200000), fp(1, 6'd32, 22'h200000));
    step("zero_opnd", OP_SUBR, fp(1, 6'd40, 22'h000000), fp(0, 6'd31, 22'h300000), fp(1, 6'd31, 22'h300000));
    step("cancel",    OP_ADDR, fp(1, 6'd31, 22'h200000), fp(0, 6'd31, 22'h200000), 29'h0);
    step("underflow", OP_SUBI, fp(0, 6'd1, 22'h200000), fp(0, 6'd1, 22'h180000), fp(0, 6'd0, 22'h100000));
    step("far_rne",   OP_SUBR, fp(0, 6'd40, 22'h200000), fp(0, 6'd0, 22'h3FFFFF), fp(0, 6'd40, 22'h200000));
    step("far_trunc", OP_SUBI, fp(0, 6'd40, 22'h200000), fp(0, 6'd0, 22'h3FFFFF), fp(0, 6'd39, 22'h3FFFFF));
    step("overflow",  OP_ADDI, fp(0, 6'd63, 22'h3FFFFF), fp(0, 6'd63, 22'h3FFFFF), OVF);

    rst = 1'b1;
    step("rst_wins",  OP_ADDI, fp(0, 6'd63, 22'h3FFFFF), fp(0, 6'd63, 22'h3FFFFF), 29'h0);
    rst = 1'b0;
    step("post_rst",  OP_ADDI, fp(0, E1, 22'h200000), fp(0, E1, 22'h200000), fp(0, 6'd32, 22'h200000));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
